// File: rtl/serial_subtractor_nbit_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// PortOvf exists only when SUB_OVERFLOW_EN is defined.
interface serial_subtractor_nbit_if #(
    parameter int SIZE = 4
);
    logic            PortStart;
    logic [SIZE-1:0] PortA_nbit;
    logic [SIZE-1:0] PortB_nbit;
    logic            PortBin_nbit;
    logic [SIZE-1:0] PortD_nbit;
    logic            PortBout;
    logic            PortBusy;
    logic            PortDone;
`ifdef SUB_OVERFLOW_EN
    logic            PortOvf;

    modport master (
        output PortStart, PortA_nbit, PortB_nbit, PortBin_nbit,
        input  PortD_nbit, PortBout, PortBusy, PortDone, PortOvf
    );
    modport slave (
        input  PortStart, PortA_nbit, PortB_nbit, PortBin_nbit,
        output PortD_nbit, PortBout, PortBusy, PortDone, PortOvf
    );
`else
    modport master (
        output PortStart, PortA_nbit, PortB_nbit, PortBin_nbit,
        input  PortD_nbit, PortBout, PortBusy, PortDone
    );
    modport slave (
        input  PortStart, PortA_nbit, PortB_nbit, PortBin_nbit,
        output PortD_nbit, PortBout, PortBusy, PortDone
    );
`endif
endinterface

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial subtractor D = A - B - Bin, LSB first, one bit per clock, single borrow flop.
// Optional signed-overflow output enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor_nbit #(
    parameter int SIZE = 4
) (
    input  logic                    PortClk,
    input  logic                    PortRst_n,
    serial_subtractor_nbit_if.slave bus
);
    localparam int CNT_W = (SIZE > 2) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              busy;
    logic              done;

    logic [CNT_W-1:0]  cnt;
    logic [SIZE-1:0]   a_sr;
    logic [SIZE-1:0]   b_sr;
    logic              br;
    logic [SIZE-2:0]   res_sr;
    logic [SIZE-1:0]   d_q;
    logic              bout_q;

    logic              accept;
    logic              last_bit;
    logic              bit_d;
    logic              br_next;
    logic [SIZE-1:0]   res_next;

    assign accept   = bus.PortStart && ((state == IDLE) || (state == DONE));
    assign last_bit = (state == SHIFT) && (cnt == CNT_W'(SIZE - 1));

    // One full-subtractor cell evaluated on the current LSBs.
    assign bit_d    = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    // Difference bits enter at the MSB; after SIZE shifts the word is aligned.
    assign res_next = {bit_d, res_sr};

    always_ff @(posedge PortClk or negedge PortRst_n) begin
        if (!PortRst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.PortStart) state_next = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == CNT_W'(SIZE - 1)) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = bus.PortStart ? SHIFT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PortClk or negedge PortRst_n) begin
        if (!PortRst_n) begin
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            br     <= 1'b0;
            res_sr <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            a_sr   <= bus.PortA_nbit;
            b_sr   <= bus.PortB_nbit;
            br     <= bus.PortBin_nbit;
            res_sr <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
        end else if (state == SHIFT) begin
            cnt    <= cnt + CNT_W'(1);
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            br     <= br_next;
            res_sr <= res_next[SIZE-1:1];
            if (last_bit) begin
                d_q    <= res_next;
                bout_q <= br_next;
            end
        end
    end

`ifdef SUB_OVERFLOW_EN
    // Sign bits of the captured operands; the shift registers lose them.
    logic a_msb;
    logic b_msb;
    logic ovf_q;

    always_ff @(posedge PortClk or negedge PortRst_n) begin
        if (!PortRst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            a_msb <= bus.PortA_nbit[SIZE-1];
            b_msb <= bus.PortB_nbit[SIZE-1];
            ovf_q <= 1'b0;
        end else if (last_bit) begin
            ovf_q <= (a_msb ^ b_msb) & (bit_d ^ a_msb);
        end
    end

    assign bus.PortOvf = ovf_q;
`endif

    assign bus.PortD_nbit = d_q;
    assign bus.PortBout   = bout_q;
    assign bus.PortBusy   = busy;
    assign bus.PortDone   = done;

endmodule
